// File: rtl/in_buff_sched.sv
// rtl/in_buff_sched.sv - burst round-robin scheduler draining NUM_CH FWFT channel FIFOs into one stream
//
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   en          : scheduler enable; low only blocks new grants
//   fifo_count  : packed per-channel occupancy, ch k at [k*(ADDR_WIDTH+1) +: ADDR_WIDTH+1]
//   fifo_data   : packed first-word-fall-through head word per channel
//   rd_en       : one-hot pop strobe back to the channel FIFOs
//   m_valid/m_ready/m_data/m_ch/m_last : registered output stream with channel tag and burst end
//   busy        : high while a burst is being served
module in_buff_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_CH     = 4,
    parameter int BURST      = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 en,
    input  logic [NUM_CH*(ADDR_WIDTH+1)-1:0]     fifo_count,
    input  logic [NUM_CH*DATA_WIDTH-1:0]         fifo_data,
    output logic [NUM_CH-1:0]                    rd_en,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [DATA_WIDTH-1:0]                m_data,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] m_ch,
    output logic                                 m_last,
    output logic                                 busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW   = ADDR_WIDTH + 1;
    localparam int BW   = $clog2(BURST) + 1;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t          state, state_nxt;
    logic [CH_W-1:0] grant, last_grant, pick;
    logic            any_elig;
    logic [BW-1:0]   beat;
    logic            pop, final_pop, start;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = last_grant;
        any_elig = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(last_grant) + i) % NUM_CH;
            if (!any_elig && (fifo_count[idx*CW +: CW] >= CW'(BURST))) begin
                any_elig = 1'b1;
                pick     = CH_W'(idx);
            end
        end
    end

    // A pop needs beats left and a free (or draining) output register.
    // Gated by reset so a burst abandoned by reset never pops in that cycle.
    assign pop       = (state == S_BURST) && !reset && (beat < BW'(BURST)) &&
                       (!m_valid || m_ready);
    assign final_pop = pop && (beat == BW'(BURST - 1));
    assign start     = (state == S_IDLE) && en && any_elig;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en && any_elig) state_nxt = S_BURST;
            S_BURST: if (final_pop)      state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == S_BURST);
        rd_en = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            rd_en[k] = pop && (grant == CH_W'(k));
        end
    end

    // Grant bookkeeping and beat counter; beat tops out at BURST on the final pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant      <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            beat       <= '0;
        end else if (start) begin
            grant      <= pick;
            last_grant <= pick;
            beat       <= '0;
        end else if (pop) begin
            beat       <= beat + 1'b1;
        end
    end

    // Output register: loads on pop, holds under backpressure, empties on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ch    <= '0;
            m_last  <= 1'b0;
        end else if (pop) begin
            m_valid <= 1'b1;
            m_data  <= fifo_data[grant*DATA_WIDTH +: DATA_WIDTH];
            m_ch    <= grant;
            m_last  <= (beat == BW'(BURST - 1));
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
